// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths, ALU op codes, forward selects,
// and the ID/EX pipeline payload.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RADDR = 5;
  localparam int unsigned ALUW  = 4;
  localparam int unsigned FWDW  = 2;

  localparam logic [ALUW-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUW-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUW-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUW-1:0] ALU_MUL = 4'b0011;
  localparam logic [ALUW-1:0] ALU_SLL = 4'b0100;
  localparam logic [ALUW-1:0] ALU_SRL = 4'b0101;
  localparam logic [ALUW-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUW-1:0] ALU_XOR = 4'b0111;

  localparam logic [FWDW-1:0] FWD_REG   = 2'b00;
  localparam logic [FWDW-1:0] FWD_MEMWB = 2'b01;
  localparam logic [FWDW-1:0] FWD_EXMEM = 2'b10;

  // Contents of the ID/EX register; all-zero is a bubble.
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [RADDR-1:0] rs1;
    logic [RADDR-1:0] rs2;
    logic [RADDR-1:0] rd;
    logic [ALUW-1:0]  alu_control;
    logic             alu_src;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
  } id_ex_t;

  // True when a writing stage targets a non-zero register equal to rs.
  function automatic logic fwd_hit(input logic we,
                                   input logic [RADDR-1:0] rd,
                                   input logic [RADDR-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding selects for the EX stage; EX/MEM beats MEM/WB, x0 never forwards.
module forward_unit
  import riscv_pkg::*;
(
  input  logic [RADDR-1:0] rs1,
  input  logic [RADDR-1:0] rs2,
  input  logic             exmem_reg_write,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic             memwb_reg_write,
  input  logic [RADDR-1:0] memwb_rd,
  output logic [FWDW-1:0]  fwd_a_sel,
  output logic [FWDW-1:0]  fwd_b_sel
);

  // Priority select per source operand.
  always_comb begin
    fwd_a_sel = FWD_REG;
    fwd_b_sel = FWD_REG;
    if (fwd_hit(exmem_reg_write, exmem_rd, rs1))      fwd_a_sel = FWD_EXMEM;
    else if (fwd_hit(memwb_reg_write, memwb_rd, rs1)) fwd_a_sel = FWD_MEMWB;
    if (fwd_hit(exmem_reg_write, exmem_rd, rs2))      fwd_b_sel = FWD_EXMEM;
    else if (fwd_hit(memwb_reg_write, memwb_rd, rs2)) fwd_b_sel = FWD_MEMWB;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding and load-use bubble insertion.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RADDR-1:0] id_rs1,
  input  logic [RADDR-1:0] id_rs2,
  input  logic [RADDR-1:0] id_rd,
  input  logic [ALUW-1:0]  id_alu_control,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_branch,
  input  logic             exmem_reg_write,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic [XLEN-1:0]  memwb_result,
  output logic             ex_valid,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [ALUW-1:0]  alu_control,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [XLEN-1:0]  ex_pc,
  output logic [RADDR-1:0] ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             load_use_hazard
);

  id_ex_t          ex_q, ex_d;
  logic [FWDW-1:0] fwd_a_sel, fwd_b_sel;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  assign load_use_hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                           ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

  // Next-state: flush > stall > load-use bubble > capture decode.
  always_comb begin
    ex_d             = '0;
    ex_d.valid       = id_valid;
    ex_d.pc          = id_pc;
    ex_d.rs1_data    = id_rs1_data;
    ex_d.rs2_data    = id_rs2_data;
    ex_d.imm         = id_imm;
    ex_d.rs1         = id_rs1;
    ex_d.rs2         = id_rs2;
    ex_d.rd          = id_rd;
    ex_d.alu_control = id_alu_control;
    ex_d.alu_src     = id_alu_src;
    ex_d.reg_write   = id_reg_write & id_valid;
    ex_d.mem_read    = id_mem_read  & id_valid;
    ex_d.mem_write   = id_mem_write & id_valid;
    ex_d.branch      = id_branch    & id_valid;
    if (flush)                ex_d = '0;
    else if (stall)           ex_d = ex_q;
    else if (load_use_hazard) ex_d = '0;
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  forward_unit u_forward_unit (
    .rs1             (ex_q.rs1),
    .rs2             (ex_q.rs2),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel)
  );

  // Operand muxes driven by the forward selects.
  always_comb begin
    rs1_fwd = ex_q.rs1_data;
    rs2_fwd = ex_q.rs2_data;
    case (fwd_a_sel)
      FWD_EXMEM: rs1_fwd = exmem_result;
      FWD_MEMWB: rs1_fwd = memwb_result;
      default:   rs1_fwd = ex_q.rs1_data;
    endcase
    case (fwd_b_sel)
      FWD_EXMEM: rs2_fwd = exmem_result;
      FWD_MEMWB: rs2_fwd = memwb_result;
      default:   rs2_fwd = ex_q.rs2_data;
    endcase
  end

  assign alu_a         = rs1_fwd;
  assign alu_b         = ex_q.alu_src ? ex_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign ex_valid      = ex_q.valid;
  assign alu_control   = ex_q.alu_control;
  assign ex_pc         = ex_q.pc;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
  assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
  assign ex_mem_write  = ex_q.valid & ex_q.mem_write;
  assign ex_branch     = ex_q.valid & ex_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios then random traffic.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic        alu_src, reg_write, mem_read, mem_write, branch;
  } ins_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] a, b, store, pc;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [3:0]  ctl;
    logic        hz;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush;
  ins_t        id;
  logic        exmem_we, memwb_we;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_res, memwb_res;

  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, load_use_hazard;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [3:0]  alu_control;
  logic [4:0]  ex_rd;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id.valid), .id_pc(id.pc), .id_rs1_data(id.rs1_data), .id_rs2_data(id.rs2_data),
    .id_imm(id.imm), .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .id_alu_control(id.alu), .id_alu_src(id.alu_src), .id_reg_write(id.reg_write),
    .id_mem_read(id.mem_read), .id_mem_write(id.mem_write), .id_branch(id.branch),
    .exmem_reg_write(exmem_we), .exmem_rd(exmem_rd), .exmem_result(exmem_res),
    .memwb_reg_write(memwb_we), .memwb_rd(memwb_rd), .memwb_result(memwb_res),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .load_use_hazard(load_use_hazard)
  );

  exp_t q[$];
  ins_t m;            // instruction the model believes sits in EX
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference: value an EX operand reads given the current writers.
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
    if (exmem_we && exmem_rd != 0 && exmem_rd == r) return exmem_res;
    if (memwb_we && memwb_rd != 0 && memwb_rd == r) return memwb_res;
    return v;
  endfunction

  function automatic logic hazard_now();
    return m.valid && m.mem_read && m.rd != 0 && id.valid &&
           (m.rd == id.rs1 || m.rd == id.rs2);
  endfunction

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic tick();
    logic hz;
    @(posedge clk);
    hz = hazard_now();
    if (reset || flush) m = '0;
    else if (stall) m = m;
    else if (hz) m = '0;
    else begin
      m = id;
      if (!id.valid) begin
        m.reg_write = 1'b0; m.mem_read = 1'b0; m.mem_write = 1'b0; m.branch = 1'b0;
      end
    end
    #1;
  endtask

  // Expected outputs for the current cycle given the model and live inputs.
  task automatic push();
    exp_t e;
    logic [31:0] s;
    s       = fwd(m.rs2, m.rs2_data);
    e.valid = m.valid;
    e.a     = fwd(m.rs1, m.rs1_data);
    e.store = s;
    e.b     = m.alu_src ? m.imm : s;
    e.pc    = m.pc;
    e.rd    = m.rd;
    e.alu   = m.alu;
    e.ctl   = m.valid ? {m.reg_write, m.mem_read, m.mem_write, m.branch} : 4'b0;
    e.hz    = hazard_now();
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_valid",  32'(ex_valid), 32'(e.valid));
        chk("alu_a",     alu_a, e.a);
        chk("alu_b",     alu_b, e.b);
        chk("alu_ctl",   32'(alu_control), 32'(e.alu));
        chk("store",     ex_store_data, e.store);
        chk("ex_pc",     ex_pc, e.pc);
        chk("ex_rd",     32'(ex_rd), 32'(e.rd));
        chk("controls",  32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}), 32'(e.ctl));
        chk("hazard",    32'(load_use_hazard), 32'(e.hz));
      end
    end
  end

  function automatic ins_t rand_ins();
    ins_t i;
    i.valid     = ($urandom_range(0, 7) != 0);
    i.pc        = $urandom;
    i.rs1_data  = $urandom;
    i.rs2_data  = $urandom;
    i.imm       = $urandom;
    i.rs1       = 5'($urandom_range(0, 7));
    i.rs2       = 5'($urandom_range(0, 7));
    i.rd        = 5'($urandom_range(0, 7));
    i.alu       = 4'($urandom_range(0, 7));
    i.alu_src   = 1'($urandom_range(0, 1));
    i.reg_write = 1'($urandom_range(0, 1));
    i.mem_read  = ($urandom_range(0, 2) == 0);
    i.mem_write = 1'($urandom_range(0, 1));
    i.branch    = 1'($urandom_range(0, 1));
    return i;
  endfunction

  function automatic ins_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] d1, input logic [31:0] d2);
    ins_t i;
    i = '0;
    i.valid = 1'b1; i.pc = 32'h0000_1000; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    i.rs1_data = d1; i.rs2_data = d2; i.alu = 4'b0010; i.reg_write = 1'b1;
    return i;
  endfunction

  task automatic fwd_off();
    exmem_we = 1'b0; exmem_rd = '0; exmem_res = '0;
    memwb_we = 1'b0; memwb_rd = '0; memwb_res = '0;
  endtask

  initial begin
    ins_t t;
    m = '0;
    // Reset with stale decode inputs.
    reset = 1'b1; stall = 1'b0; flush = 1'b0; fwd_off();
    id = rand_ins(); id.valid = 1'b1;
    tick();
    id = rand_ins(); id.valid = 1'b1; push(); tick();
    // Basic load: add with rs1=5, rs2=7.
    reset = 1'b0;
    id = mk(5'd1, 5'd2, 5'd5, 32'd5, 32'd7); push(); tick();
    // Immediate select.
    t = mk(5'd1, 5'd2, 5'd6, 32'd9, 32'h1234); t.alu_src = 1'b1; t.imm = 32'hFFFF_FFF0;
    id = t; push(); tick();
    // Instruction reading x3, then both writers target x3.
    id = mk(5'd3, 5'd2, 5'd7, 32'h11, 32'h22); push(); tick();
    exmem_we = 1'b1; exmem_rd = 5'd3; exmem_res = 32'hAA;
    memwb_we = 1'b1; memwb_rd = 5'd3; memwb_res = 32'hBB;
    id = mk(5'd0, 5'd1, 5'd8, 32'h55, 32'h66); push(); tick();
    // x0 must not forward.
    exmem_we = 1'b1; exmem_rd = 5'd0; exmem_res = 32'hAA;
    memwb_we = 1'b0; memwb_rd = 5'd0; memwb_res = 32'h0;
    t = mk(5'd1, 5'd2, 5'd4, 32'h1, 32'h2); t.mem_read = 1'b1;
    id = t; push(); tick();
    // Load-use: consumer of x4 right behind a lw to x4.
    fwd_off();
    id = mk(5'd6, 5'd4, 5'd9, 32'h77, 32'h88); push(); tick();
    push(); tick();
    // Flush and stall together, then stall alone.
    id = mk(5'd1, 5'd2, 5'd3, 32'h10, 32'h20);
    flush = 1'b1; stall = 1'b1; push(); tick();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin id = rand_ins(); push(); tick(); end
    stall = 1'b0;
    id = mk(5'd1, 5'd2, 5'd3, 32'h10, 32'h20); push(); tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin id = rand_ins(); push(); tick(); end
    stall = 1'b0;
    // Random traffic with hazards, forwarding, stalls, flushes and resets.
    for (int k = 0; k < 500; k++) begin
      reset     = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      stall     = ($urandom_range(0, 5) == 0);
      id        = rand_ins();
      exmem_we  = 1'($urandom_range(0, 1));
      exmem_rd  = 5'($urandom_range(0, 7));
      exmem_res = $urandom;
      memwb_we  = 1'($urandom_range(0, 1));
      memwb_rd  = 5'($urandom_range(0, 7));
      memwb_res = $urandom;
      push(); tick();
    end
    reset = 1'b0; flush = 1'b0; stall = 1'b0;
    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
